toggle_cover_collector: RTL and testbench

- Parametrised toggle-coverage collector for formal/fuzz coverage instrumentation.
- Detects real per-bit 0->1 and 1->0 transitions on a WIDTH-bit probe vector and keeps sticky hit bits, one per point, two points per bit.
- Drains each newly covered point exactly once through a valid/ready report port, so no per-bit simulator callback is needed.
- Sits beside an instrumented RTL signal; the report port feeds the coverage aggregator.

---
 rtl/toggle_cover_collector_if.sv | 32 +++
 rtl/toggle_cover_collector.sv | 155 +++++++++++++++
 tb/tb_toggle_cover_collector.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_cover_collector_if.sv
// Report channel of the toggle-coverage collector: one newly covered point
// per valid/ready handshake.
//   report_valid  - a new cover point is presented (collector -> consumer)
//   report_ready  - consumer accepts the point      (consumer -> collector)
//   report_index  - global cover point index
//   report_dir    - 0 = rise (0->1), 1 = fall (1->0)
interface toggle_cover_collector_if #(
  parameter int unsigned IDX_W = 32
) ();

  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_index;
  logic             report_dir;

  // Collector side
  modport master (
    output report_valid,
    output report_index,
    output report_dir,
    input  report_ready
  );

  // Coverage aggregator side
  modport slave (
    input  report_valid,
    input  report_index,
    input  report_dir,
    output report_ready
  );

endinterface

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: watches a WIDTH-bit probe vector, records each
// bit's first 0->1 and 1->0 transition as sticky hit points and drains every
// newly hit point exactly once through a valid/ready report channel.
//   clock         - design clock
//   reset         - synchronous, active-high reset
//   enable        - detection enable (pending reports drain regardless)
//   clear         - synchronous coverage clear (drops any held report)
//   sample        - probed signal vector
//   report        - report channel (valid/ready/index/dir), master side
//   covered_count - number of points hit since reset/clear
//   all_covered   - every point (2*WIDTH) has been hit
module toggle_cover_collector #(
  parameter int unsigned WIDTH       = 36,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned IDX_W       = 32,
  localparam int unsigned CNT_W      = $clog2(2 * WIDTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         sample,
  toggle_cover_collector_if.master report,
  output logic [CNT_W-1:0]         covered_count,
  output logic                     all_covered
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Sampling history
  logic [WIDTH-1:0] prev;
  logic             prev_valid;

  // Sticky hit bits and not-yet-reported bits, one of each per point
  logic [WIDTH-1:0] hit_rise;
  logic [WIDTH-1:0] hit_fall;
  logic [WIDTH-1:0] pend_rise;
  logic [WIDTH-1:0] pend_fall;

  // Registered report and count outputs
  logic             rpt_valid;
  logic [IDX_W-1:0] rpt_index;
  logic             rpt_dir;
  logic [CNT_W-1:0] count_q;
  logic             all_q;

  // Combinational detection / selection
  logic             det_en;
  logic [WIDTH-1:0] rise_det;
  logic [WIDTH-1:0] fall_det;
  logic [WIDTH-1:0] new_rise;
  logic [WIDTH-1:0] new_fall;
  logic [CNT_W-1:0] add_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load;
  logic             sel_any;
  logic [BIT_W-1:0] sel_bit;
  logic             sel_dir;
  logic [WIDTH-1:0] rise_sel;
  logic [WIDTH-1:0] fall_sel;
  logic [WIDTH-1:0] rise_drop;
  logic [WIDTH-1:0] fall_drop;

  assign report.report_valid = rpt_valid;
  assign report.report_index = rpt_index;
  assign report.report_dir   = rpt_dir;
  assign covered_count       = count_q;
  assign all_covered         = all_q;

  // The first sample after reset/clear only primes prev; it is never a toggle
  assign det_en   = enable & prev_valid;
  assign rise_det = det_en ? (~prev &  sample) : '0;
  assign fall_det = det_en ? ( prev & ~sample) : '0;

  // Only points not yet hit produce new coverage
  assign new_rise = rise_det & ~hit_rise;
  assign new_fall = fall_det & ~hit_fall;

  // Several bits may toggle in one cycle: count every newly hit point
  always_comb begin
    add_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      add_cnt = add_cnt + CNT_W'(new_rise[i]) + CNT_W'(new_fall[i]);
    end
  end

  // Hits are sticky, so the sum can never exceed 2*WIDTH
  assign cnt_next = count_q + add_cnt;

  // Report slot is free when empty or being accepted this cycle
  assign load = ~rpt_valid | report.report_ready;

  // Lowest bit with anything pending wins; rise before fall on the same bit.
  // Uses registered pending bits only, so same-cycle detections wait a cycle.
  always_comb begin
    sel_any  = 1'b0;
    sel_bit  = '0;
    sel_dir  = 1'b0;
    rise_sel = '0;
    fall_sel = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!sel_any && (pend_rise[i] || pend_fall[i])) begin
        sel_any = 1'b1;
        sel_bit = BIT_W'(i);
        sel_dir = ~pend_rise[i];
        if (pend_rise[i]) begin
          rise_sel[i] = 1'b1;
        end else begin
          fall_sel[i] = 1'b1;
        end
      end
    end
  end

  // Pending bit retired at the edge that loads it into the report register
  assign rise_drop = load ? rise_sel : '0;
  assign fall_drop = load ? fall_sel : '0;

  // State update: reset beats clear beats normal operation
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      if (reset) begin
        prev <= '0;
      end
      prev_valid <= 1'b0;
      hit_rise   <= '0;
      hit_fall   <= '0;
      pend_rise  <= '0;
      pend_fall  <= '0;
      rpt_valid  <= 1'b0;
      rpt_index  <= '0;
      rpt_dir    <= 1'b0;
      count_q    <= '0;
      all_q      <= 1'b0;
    end else begin
      prev       <= sample;
      prev_valid <= 1'b1;
      hit_rise   <= hit_rise | new_rise;
      hit_fall   <= hit_fall | new_fall;
      pend_rise  <= (pend_rise & ~rise_drop) | new_rise;
      pend_fall  <= (pend_fall & ~fall_drop) | new_fall;
      count_q    <= cnt_next;
      all_q      <= (cnt_next == CNT_W'(2 * WIDTH));
      if (load) begin
        rpt_valid <= sel_any;
        if (sel_any) begin
          // index = COVER_INDEX + 2*bit + dir
          rpt_index <= IDX_W'(COVER_INDEX) + IDX_W'({sel_bit, sel_dir});
          rpt_dir   <= sel_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Self-checking bench for toggle_cover_collector (WIDTH=4, COVER_INDEX=100).
// A vector table checks per-cycle outputs; a scoreboard queue checks the
// order and content of every accepted report.
module tb_toggle_cover_collector;

  localparam int unsigned WIDTH       = 4;
  localparam int unsigned COVER_INDEX = 100;
  localparam int unsigned IDX_W       = 32;
  localparam int unsigned NVEC        = 21;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] sample;
  logic [3:0] covered_count;
  logic       all_covered;

  toggle_cover_collector_if #(.IDX_W(IDX_W)) rpt_if ();

  toggle_cover_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (COVER_INDEX),
    .IDX_W       (IDX_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .sample        (sample),
    .report        (rpt_if.master),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_q[$];
  int unsigned sb_exp;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic [3:0]  smp;
    logic [7:0]  push;   // points (2*bit+dir) newly covered by this row
    logic        ev;
    int unsigned eidx;
    logic        edir;
    logic [3:0]  ecnt;
    logic        eall;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic en, input logic rdy,
                              input logic [3:0] smp, input logic [7:0] push,
                              input logic ev, input int unsigned eidx,
                              input logic edir, input logic [3:0] ecnt,
                              input logic eall);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.smp = smp; v.push = push;
    v.ev = ev; v.eidx = eidx; v.edir = edir; v.ecnt = ecnt; v.eall = eall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic en,
                       input logic rdy, input logic [3:0] smp);
    @(negedge clock);
    reset  = rst;
    clear  = clr;
    enable = en;
    rpt_if.report_ready = rdy;
    sample = smp;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input int unsigned eidx,
                            input logic edir, input logic [3:0] ecnt, input logic eall);
    check({tag, "_valid"}, 32'(rpt_if.report_valid), 32'(ev));
    if (ev) begin
      check({tag, "_index"}, rpt_if.report_index, eidx);
      check({tag, "_dir"}, 32'(rpt_if.report_dir), 32'(edir));
    end
    check({tag, "_count"}, 32'(covered_count), 32'(ecnt));
    check({tag, "_all"}, 32'(all_covered), 32'(eall));
  endtask

  // Scoreboard: every accepted report must match the next expected point
  always @(posedge clock) begin
    if (!reset && !clear && rpt_if.report_valid && rpt_if.report_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got index %0d expected none", rpt_if.report_index);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_index", rpt_if.report_index, sb_exp);
        check("sb_dir", 32'(rpt_if.report_dir), (sb_exp - COVER_INDEX) % 2);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    clear  = 1'b0;
    enable = 1'b1;
    sample = 4'b0000;
    rpt_if.report_ready = 1'b1;

    //              rst en rdy smp      push   ev idx  dir cnt all
    // 0000 -> 0001 -> 0000: rise then fall of bit 0
    vecs[0]  = mk(1, 1, 1, 4'b0000, 8'h00, 0, 0,   0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 4'b0000, 8'h00, 0, 0,   0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 4'b0001, 8'h01, 0, 0,   0, 1, 0);
    vecs[3]  = mk(0, 1, 1, 4'b0000, 8'h02, 1, 100, 0, 2, 0);
    vecs[4]  = mk(0, 1, 1, 4'b0000, 8'h00, 1, 101, 1, 2, 0);
    vecs[5]  = mk(0, 1, 1, 4'b0000, 8'h00, 0, 0,   0, 2, 0);
    // first sample after reset is never a toggle
    vecs[6]  = mk(1, 1, 1, 4'b0000, 8'h00, 0, 0,   0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 4'b1111, 8'h00, 0, 0,   0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 4'b1111, 8'h00, 0, 0,   0, 0, 0);
    // 0000 -> 1111 with back-pressure, then drain one per cycle
    vecs[9]  = mk(1, 1, 0, 4'b0000, 8'h00, 0, 0,   0, 0, 0);
    vecs[10] = mk(0, 1, 0, 4'b0000, 8'h00, 0, 0,   0, 0, 0);
    vecs[11] = mk(0, 1, 0, 4'b1111, 8'h55, 0, 0,   0, 4, 0);
    vecs[12] = mk(0, 1, 0, 4'b1111, 8'h00, 1, 100, 0, 4, 0);
    vecs[13] = mk(0, 1, 0, 4'b1111, 8'h00, 1, 100, 0, 4, 0);
    vecs[14] = mk(0, 1, 0, 4'b1111, 8'h00, 1, 100, 0, 4, 0);
    vecs[15] = mk(0, 1, 0, 4'b1111, 8'h00, 1, 100, 0, 4, 0);
    vecs[16] = mk(0, 1, 0, 4'b1111, 8'h00, 1, 100, 0, 4, 0);
    vecs[17] = mk(0, 1, 1, 4'b1111, 8'h00, 1, 102, 0, 4, 0);
    vecs[18] = mk(0, 1, 1, 4'b1111, 8'h00, 1, 104, 0, 4, 0);
    vecs[19] = mk(0, 1, 1, 4'b1111, 8'h00, 1, 106, 0, 4, 0);
    vecs[20] = mk(0, 1, 1, 4'b1111, 8'h00, 0, 0,   0, 4, 0);

    for (int i = 0; i < int'(NVEC); i++) begin
      for (int p = 0; p < 8; p++) begin
        if (vecs[i].push[p]) exp_q.push_back(COVER_INDEX + 32'(p));
      end
      drive(vecs[i].rst, 1'b0, vecs[i].en, vecs[i].rdy, vecs[i].smp);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].edir,
                 vecs[i].ecnt, vecs[i].eall);
    end

    // Repeated toggling of bit 0 reports each direction once
    drive(1, 0, 1, 1, 4'b0000);
    drive(0, 0, 1, 1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) exp_q.push_back(COVER_INDEX);
      if (i == 1) exp_q.push_back(COVER_INDEX + 1);
      drive(0, 0, 1, 1, (i % 2 == 0) ? 4'b0001 : 4'b0000);
    end
    drive(0, 0, 1, 1, 4'b0000);
    drive(0, 0, 1, 1, 4'b0000);
    expect_out("rep20", 0, 0, 0, 4'd2, 0);

    // Full coverage, then clear while point 107 is held
    drive(1, 0, 1, 1, 4'b0000);
    drive(0, 0, 1, 1, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(COVER_INDEX + 32'(2 * b));
      drive(0, 0, 1, 1, 4'(1 << b));
      if (b != 3) exp_q.push_back(COVER_INDEX + 32'(2 * b + 1));
      drive(0, 0, 1, 1, 4'b0000);
    end
    expect_out("full_a", 1, 106, 0, 4'd8, 1);
    drive(0, 0, 1, 1, 4'b0000);
    expect_out("full_b", 1, 107, 1, 4'd8, 1);
    drive(0, 0, 1, 0, 4'b0000);
    drive(0, 0, 1, 0, 4'b0000);
    expect_out("hold107", 1, 107, 1, 4'd8, 1);
    drive(0, 1, 1, 0, 4'b0000);
    expect_out("clear", 0, 0, 0, 4'd0, 0);
    check("clear_index", rpt_if.report_index, 0);
    drive(0, 0, 1, 0, 4'b0000);
    expect_out("post_clr", 0, 0, 0, 4'd0, 0);
    exp_q.push_back(COVER_INDEX + 6);
    drive(0, 0, 1, 1, 4'b1000);
    expect_out("clr_det", 0, 0, 0, 4'd1, 0);
    drive(0, 0, 1, 1, 4'b1000);
    expect_out("clr_rep", 1, 106, 0, 4'd1, 0);
    drive(0, 0, 1, 1, 4'b1000);
    expect_out("clr_done", 0, 0, 0, 4'd1, 0);

    // enable=0 records nothing; pending reports still drain after disable
    drive(1, 0, 0, 1, 4'b0000);
    drive(0, 0, 0, 1, 4'b0000);
    drive(0, 0, 0, 1, 4'b0010);
    drive(0, 0, 0, 1, 4'b0000);
    drive(0, 0, 0, 1, 4'b0010);
    drive(0, 0, 0, 1, 4'b0000);
    expect_out("dis", 0, 0, 0, 4'd0, 0);
    exp_q.push_back(COVER_INDEX + 2);
    drive(0, 0, 1, 1, 4'b0010);
    expect_out("en_det", 0, 0, 0, 4'd1, 0);
    drive(0, 0, 0, 1, 4'b0010);
    expect_out("en_rep", 1, 102, 0, 4'd1, 0);
    drive(0, 0, 0, 1, 4'b0000);
    expect_out("en_done", 0, 0, 0, 4'd1, 0);

    drive(0, 0, 1, 1, 4'b0000);
    drive(0, 0, 1, 1, 4'b0000);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
